mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Sequences every load/store of the MEM stage onto an external 16-bit-wide SRAM, one 32-bit word as two half-word phases.
Drives the MEM stage register enable (via freeze) so the pipeline holds while an access is in flight.
Sits between the EXE/MEM pipeline register outputs and the MEM stage register inputs.
Translates CPU byte addresses to SRAM half-word addresses.

Parameters:
DATA_W, 32, CPU data/address width
SRAM_DW, 16, SRAM data bus width; fixed at DATA_W/2
SRAM_AW, 18, SRAM half-word address width
WAIT_CYCLES, 1, cycles each half-word phase is held; legal range 1..15
BASE_ADDR, 1024, first CPU data address mapped to SRAM half-word 0

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous, active-low reset; rst=0 at a rising edge resets the block
MEM_R_EN  in  1  load request from EXE/MEM register
MEM_W_EN  in  1  store request from EXE/MEM register
addr  in  32  CPU byte address (ALU result)
wdata  in  32  store data
rdata  out  32  assembled load data
ready  out  1  access finished or no access pending
freeze  out  1  pipeline hold: (MEM_R_EN|MEM_W_EN) & ~ready; MEM register en = ~freeze
SRAM_ADDR  out  18  SRAM half-word address
SRAM_DQ  inout  16  SRAM data bus
SRAM_WE_N  out  1  SRAM write strobe, active low
SRAM_OE_N  out  1  SRAM output enable, active low

Behaviour:
- States: IDLE, LO, HI, DONE. A 4-bit phase counter counts 0..WAIT_CYCLES-1.
- Reset (rst=0 at clk edge, including mid-access):
  - State goes to IDLE and the counter to 0.
  - rdata=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - An aborted access is dropped; a partial store is possible and accepted.
- IDLE:
  - If MEM_W_EN|MEM_R_EN, latch op (write wins if both are set; both set is illegal), addr and wdata, then go to LO.
  - Otherwise stay in IDLE.
  - ready = ~(MEM_R_EN|MEM_W_EN).
- Address: word = (addr - BASE_ADDR) mod 2^32, then >>2.
  - SRAM_ADDR = {word[SRAM_AW-2:0], half}; half=0 in LO, 1 in HI.
  - addr[1:0] is ignored. Addresses below BASE_ADDR wrap; upper bits are truncated.
- LO and HI:
  - Each lasts exactly WAIT_CYCLES cycles, then advances (LO->HI, HI->DONE).
  - Write: SRAM_WE_N=0, SRAM_OE_N=1; SRAM_DQ drives wdata[15:0] in LO and wdata[31:16] in HI.
  - Read: SRAM_WE_N=1, SRAM_OE_N=0, SRAM_DQ=Z. SRAM_DQ is sampled on the last cycle of LO into rdata[15:0] and on the last cycle of HI into rdata[31:16].
- DONE:
  - One cycle, ready=1, SRAM strobes inactive, then IDLE.
  - The MEM register captures in this cycle.
- Latency: from the request first seen in IDLE to ready=1 is 2*WAIT_CYCLES+1 cycles; freeze is high for exactly that many cycles.
- rdata holds its value until the next read phase overwrites it. Writes never modify rdata.
- Request deasserted mid-access (flush): the access still completes through DONE; no early abort.
- A request present in the cycle after DONE is a new access.
- SRAM_DQ is never driven in IDLE, DONE or read states.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum (IDLE, LO, HI, DONE)
  - BASE_ADDR default
  - SRAM_DW and SRAM_AW constants
  - address-translation function
- No sub-module: the FSM, counter and tristate stay in one module.

Test Plan:
- Reset with WAIT_CYCLES=1: hold rst=0 for 2 cycles -> all outputs at reset values, SRAM_DQ=Z, ready=1 with no request.
- Store: addr=1024+8, wdata=32'hDEADBEEF.
  - SRAM_ADDR=4 with DQ=16'hBEEF for 1 cycle, then SRAM_ADDR=5 with DQ=16'hDEAD.
  - freeze high for 3 cycles, ready=1 in the 4th cycle.
- Load: SRAM model holds 16'hBEEF at 4 and 16'hDEAD at 5; addr=1032.
  - rdata=32'hDEADBEEF in DONE.
  - rdata is unchanged through a following store.
- WAIT_CYCLES=3, load: freeze high for 7 cycles; each of SRAM_ADDR=4 and 5 is held for 3 cycles.
- Back-to-back store then load, and MEM_R_EN dropped during LO -> both accesses complete in order; no DQ contention (DQ=Z whenever OE_N=0).
- rst=0 during HI of a store -> next cycle IDLE, SRAM_WE_N=1, DQ=Z; a new load afterwards has normal latency.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM access controller.
// Holds the FSM state encoding and the CPU byte address to SRAM word translation.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_SRAM_DW   = DEF_DATA_W / 2;
    localparam int DEF_SRAM_AW   = 18;
    localparam int DEF_BASE_ADDR = 1024;
    localparam int WORD_W        = DEF_SRAM_AW - 1;

    // Word index relative to the data base; wraps below base, upper bits dropped.
    function automatic logic [WORD_W-1:0] sram_word(input logic [31:0] addr,
                                                    input logic [31:0] base);
        return WORD_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bundle between the EXE/MEM register and the controller.
// Handshake: a request (MEM_R_EN or MEM_W_EN) stays asserted while freeze is high; the access is finished in the cycle where ready=1.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              freeze;

    modport master (
        output MEM_R_EN, MEM_W_EN, addr, wdata,
        input  rdata, ready, freeze
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, addr, wdata,
        output rdata, ready, freeze
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM phases (LO then HI)
// and holds the pipeline via freeze until the access reaches DONE.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int          SRAM_DW     = DEF_SRAM_DW,
    parameter int          SRAM_AW     = DEF_SRAM_AW,
    parameter int          WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_ctrl_if.slave   cpu,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output state_t             state,
    output logic               dq_oe
);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_w_q;
    logic [SRAM_AW-2:0]  word_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                req;
    logic                last;
    logic                active;
    logic                half;
    logic [SRAM_DW-1:0]  dq_out;

    assign req  = cpu.MEM_R_EN | cpu.MEM_W_EN;
    assign last = (cnt_q == 4'(WAIT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req) state_d = LO;
            LO: begin
                if (last) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_w_q  <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Write wins when both enables are set.
            if (state_q == IDLE && req) begin
                op_w_q  <= cpu.MEM_W_EN;
                word_q  <= sram_word(cpu.addr, 32'(BASE_ADDR));
                wdata_q <= cpu.wdata;
            end
            if (state_q == LO && last && !op_w_q)
                rdata_q[SRAM_DW-1:0] <= SRAM_DQ;
            if (state_q == HI && last && !op_w_q)
                rdata_q[DATA_W-1:SRAM_DW] <= SRAM_DQ;
        end
    end

    assign active    = (state_q == LO) || (state_q == HI);
    assign half      = (state_q == HI);
    assign SRAM_ADDR = active ? {word_q, half} : '0;
    assign SRAM_WE_N = !(active && op_w_q);
    assign SRAM_OE_N = !(active && !op_w_q);
    assign dq_oe     = active && op_w_q;
    assign dq_out    = half ? wdata_q[DATA_W-1:SRAM_DW] : wdata_q[SRAM_DW-1:0];
    assign SRAM_DQ   = dq_oe ? dq_out : 'z;

    // In IDLE a pending request is not yet served, so ready tracks its absence.
    assign cpu.ready  = (state_q == IDLE) ? !req : (state_q == DONE);
    assign cpu.freeze = req & ~cpu.ready;
    assign cpu.rdata  = rdata_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES=1 and 3), each with an SRAM device
// model and a cycle-count reference model checked every cycle, plus literal pins.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int BASE = 1024;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // per-instance stimulus and observed outputs
    logic        r_en [2];
    logic        w_en [2];
    logic [31:0] a_in [2];
    logic [31:0] d_in [2];
    logic [31:0] act_rdata [2];
    logic        act_ready [2];
    logic        act_freeze [2];
    logic [17:0] sa [2];
    logic        we_n [2];
    logic        oe_n [2];
    logic        dq_oe [2];
    state_t      st [2];
    logic [15:0] dq_val [2];
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    mem_access_ctrl_if bus0 ();
    mem_access_ctrl_if bus1 ();

    assign bus0.MEM_R_EN = r_en[0];
    assign bus0.MEM_W_EN = w_en[0];
    assign bus0.addr     = a_in[0];
    assign bus0.wdata    = d_in[0];
    assign bus1.MEM_R_EN = r_en[1];
    assign bus1.MEM_W_EN = w_en[1];
    assign bus1.addr     = a_in[1];
    assign bus1.wdata    = d_in[1];
    assign act_rdata[0]  = bus0.rdata;
    assign act_ready[0]  = bus0.ready;
    assign act_freeze[0] = bus0.freeze;
    assign act_rdata[1]  = bus1.rdata;
    assign act_ready[1]  = bus1.ready;
    assign act_freeze[1] = bus1.freeze;
    assign dq_val[0]     = dq0;
    assign dq_val[1]     = dq1;

    mem_access_ctrl #(.WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .cpu(bus0),
        .SRAM_ADDR(sa[0]), .SRAM_DQ(dq0), .SRAM_WE_N(we_n[0]), .SRAM_OE_N(oe_n[0]),
        .state(st[0]), .dq_oe(dq_oe[0])
    );

    mem_access_ctrl #(.WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .cpu(bus1),
        .SRAM_ADDR(sa[1]), .SRAM_DQ(dq1), .SRAM_WE_N(we_n[1]), .SRAM_OE_N(oe_n[1]),
        .state(st[1]), .dq_oe(dq_oe[1])
    );

    // SRAM device models (256 half-words, address aliased on the low 8 bits)
    logic [15:0] dev_mem [2][256];
    logic [15:0] ref_mem [2][256];
    logic        preload;
    logic [15:0] seed;

    function automatic logic [15:0] pat(input int i, input int j);
        return 16'(j * 40503 + i * 7919) ^ seed;
    endfunction

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    assign dq0 = (!oe_n[0] && we_n[0]) ? dev_mem[0][sa[0][7:0]] : 16'hzzzz;
    assign dq1 = (!oe_n[1] && we_n[1]) ? dev_mem[1][sa[1][7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload) begin
                for (int j = 0; j < 256; j++) dev_mem[i][j] <= pat(i, j);
            end else if (!we_n[i]) begin
                dev_mem[i][sa[i][7:0]] <= dq_val[i];
            end
        end
    end

    // reference model: mk = cycles into the current access (0 = no access underway)
    int          mk [2];
    logic        mw [2];
    logic [31:0] mword [2];
    logic [31:0] mwd [2];
    logic [31:0] mrd [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload) begin
                for (int j = 0; j < 256; j++) ref_mem[i][j] <= pat(i, j);
            end else begin
                if (mk[i] == wc(i) && mw[i])
                    ref_mem[i][{mword[i][6:0], 1'b0}] <= mwd[i][15:0];
                if (mk[i] == 2 * wc(i) && mw[i])
                    ref_mem[i][{mword[i][6:0], 1'b1}] <= mwd[i][31:16];
            end
            if (!rst) begin
                mk[i]  <= 0;
                mrd[i] <= 32'h0;
            end else begin
                if (mk[i] == wc(i) && !mw[i])
                    mrd[i][15:0] <= ref_mem[i][{mword[i][6:0], 1'b0}];
                if (mk[i] == 2 * wc(i) && !mw[i])
                    mrd[i][31:16] <= ref_mem[i][{mword[i][6:0], 1'b1}];
                if (mk[i] == 0) begin
                    if (r_en[i] || w_en[i]) begin
                        mk[i]    <= 1;
                        mw[i]    <= w_en[i];
                        mword[i] <= (a_in[i] - 32'(BASE)) >> 2;
                        mwd[i]   <= d_in[i];
                    end
                end else if (mk[i] == 2 * wc(i) + 1) begin
                    mk[i] <= 0;
                end else begin
                    mk[i] <= mk[i] + 1;
                end
            end
        end
    end

    // scoreboard
    int tests;
    int fails;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int     k;
            int     w;
            bit     lo, hi, dn, req, rdy, act;
            state_t es;
            k   = mk[i];
            w   = wc(i);
            lo  = (k >= 1) && (k <= w);
            hi  = (k > w) && (k <= 2 * w);
            dn  = (k == 2 * w + 1);
            act = lo || hi;
            req = r_en[i] || w_en[i];
            rdy = (k == 0) ? !req : dn;
            es  = (k == 0) ? IDLE : (lo ? LO : (hi ? HI : DONE));
            check($sformatf("ready[%0d]", i), 32'(act_ready[i]), 32'(rdy));
            check($sformatf("freeze[%0d]", i), 32'(act_freeze[i]), 32'(req && !rdy));
            check($sformatf("sram_addr[%0d]", i), 32'(sa[i]),
                  act ? 32'({mword[i][16:0], hi}) : 32'h0);
            check($sformatf("we_n[%0d]", i), 32'(we_n[i]), 32'(!(act && mw[i])));
            check($sformatf("oe_n[%0d]", i), 32'(oe_n[i]), 32'(!(act && !mw[i])));
            check($sformatf("dq_oe[%0d]", i), 32'(dq_oe[i]), 32'(act && mw[i]));
            check($sformatf("state[%0d]", i), 32'(st[i]), 32'(es));
            check($sformatf("rdata[%0d]", i), act_rdata[i], mrd[i]);
            if (act && mw[i])
                check($sformatf("dq_wr[%0d]", i), 32'(dq_val[i]),
                      32'(hi ? mwd[i][31:16] : mwd[i][15:0]));
        end
    endtask

    // driver tasks: called at a negedge, return at the next negedge
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [17:0] a_log [16];
    logic [15:0] d_log [16];
    logic        r_log [16];

    task automatic access(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int drop_at, output int fz, output logic [31:0] rd);
        int n;
        n       = 2 * wc(i) + 2;
        r_en[i] = !w;
        w_en[i] = w;
        a_in[i] = a;
        d_in[i] = d;
        fz      = 0;
        rd      = 32'h0;
        for (int c = 0; c < n; c++) begin
            if (c == drop_at) begin
                r_en[i] = 1'b0;
                w_en[i] = 1'b0;
            end
            #1;
            if (act_freeze[i]) fz++;
            a_log[c] = sa[i];
            d_log[c] = dq_val[i];
            r_log[c] = act_ready[i];
            if (c == n - 1) rd = act_rdata[i];
            tick();
        end
        r_en[i] = 1'b0;
        w_en[i] = 1'b0;
    endtask

    initial begin
        int          fz;
        logic [31:0] rd;
        int          idx;
        int          drop;
        bit          wr;
        logic [31:0] a;

        tests = 0;
        fails = 0;
        seed  = 16'($urandom);
        for (int i = 0; i < 2; i++) begin
            r_en[i] = 1'b0;
            w_en[i] = 1'b0;
            a_in[i] = 32'h0;
            d_in[i] = 32'h0;
        end
        rst     = 1'b0;
        preload = 1'b1;
        @(negedge clk);
        @(negedge clk);
        preload = 1'b0;
        #1;
        check("rst_ready", 32'(act_ready[0]), 32'h1);
        check("rst_freeze", 32'(act_freeze[0]), 32'h0);
        check("rst_sram_addr", 32'(sa[0]), 32'h0);
        check("rst_we_n", 32'(we_n[0]), 32'h1);
        check("rst_oe_n", 32'(oe_n[0]), 32'h1);
        check("rst_dq_oe", 32'(dq_oe[0]), 32'h0);
        check("rst_rdata", act_rdata[0], 32'h0);
        rst = 1'b1;
        tick();

        // store 0xDEADBEEF to 1032 -> half-words 4 and 5
        access(0, 1'b1, 32'd1032, 32'hDEADBEEF, -1, fz, rd);
        check("st_freeze_cycles", 32'(fz), 32'd3);
        check("st_lo_addr", 32'(a_log[1]), 32'd4);
        check("st_lo_dq", 32'(d_log[1]), 32'hBEEF);
        check("st_hi_addr", 32'(a_log[2]), 32'd5);
        check("st_hi_dq", 32'(d_log[2]), 32'hDEAD);
        check("st_done_ready", 32'(r_log[3]), 32'h1);

        access(0, 1'b0, 32'd1032, 32'h0, -1, fz, rd);
        check("ld_freeze_cycles", 32'(fz), 32'd3);
        check("ld_rdata", rd, 32'hDEADBEEF);

        // back-to-back store then load whose request drops during LO
        access(0, 1'b1, 32'd1036, 32'h12345678, -1, fz, rd);
        check("rdata_kept_by_store", rd, 32'hDEADBEEF);
        access(0, 1'b0, 32'd1037, 32'h0, 1, fz, rd);
        check("flushed_ld_rdata", rd, 32'h12345678);

        // reset in HI of a store
        r_en[0] = 1'b0;
        w_en[0] = 1'b1;
        a_in[0] = 32'(BASE + 40);
        d_in[0] = 32'hCAFEF00D;
        tick();
        tick();
        rst     = 1'b0;
        w_en[0] = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("rst_hi_state", 32'(st[0]), 32'(IDLE));
        check("rst_hi_we_n", 32'(we_n[0]), 32'h1);
        check("rst_hi_dq_oe", 32'(dq_oe[0]), 32'h0);
        check("rst_hi_rdata", act_rdata[0], 32'h0);
        tick();
        access(0, 1'b0, 32'd1032, 32'h0, -1, fz, rd);
        check("post_rst_freeze", 32'(fz), 32'd3);
        check("post_rst_rdata", rd, 32'hDEADBEEF);

        // WAIT_CYCLES=3 instance
        access(1, 1'b1, 32'd1032, 32'hDEADBEEF, -1, fz, rd);
        check("w3_st_freeze", 32'(fz), 32'd7);
        access(1, 1'b0, 32'd1032, 32'h0, -1, fz, rd);
        check("w3_ld_freeze", 32'(fz), 32'd7);
        check("w3_ld_rdata", rd, 32'hDEADBEEF);
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("w3_lo_addr%0d", c), 32'(a_log[c]), 32'd4);
            check($sformatf("w3_hi_addr%0d", c), 32'(a_log[c + 3]), 32'd5);
        end

        // wrapped address below base
        access(0, 1'b1, 32'd1020, 32'hA5A55A5A, -1, fz, rd);
        check("wrap_lo_addr", 32'(a_log[1]), 32'h3FFFE);
        check("wrap_hi_addr", 32'(a_log[2]), 32'h3FFFF);

        // randomized traffic on both instances
        for (int n = 0; n < 120; n++) begin
            idx = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                a = 32'(BASE) - 32'(4 * $urandom_range(1, 4));
            else
                a = 32'(BASE) + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * wc(idx))) : -1;
            access(idx, wr, a, $urandom, drop, fz, rd);
            if (drop < 0)
                check($sformatf("rnd_freeze[%0d]", idx), 32'(fz), 32'(2 * wc(idx) + 1));
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
